// File: rtl/cbfp_block_exp_ctrl.sv
// cbfp_block_exp_ctrl: counts CBFP beats into blocks/frames, reduces per-beat shifts to a
// per-block minimum exponent and queues {blk_idx, exp_re, exp_im} in a ready/valid FIFO.
module cbfp_block_exp_ctrl #(
    parameter int SHIFT_WIDTH     = 5,
    parameter int BEATS_PER_BLK   = 4,
    parameter int BEATS_PER_FRAME = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int BLK_IDX_W       = (BEATS_PER_FRAME / BEATS_PER_BLK > 1) ?
                                    $clog2(BEATS_PER_FRAME / BEATS_PER_BLK) : 1,
    parameter int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_din_valid,
    input  logic [SHIFT_WIDTH-1:0] i_shift_amt_re,
    input  logic [SHIFT_WIDTH-1:0] i_shift_amt_im,
    input  logic                   i_flush,
    input  logic                   i_exp_ready,
    output logic                   o_exp_valid,
    output logic [SHIFT_WIDTH-1:0] o_blk_exp_re,
    output logic [SHIFT_WIDTH-1:0] o_blk_exp_im,
    output logic [BLK_IDX_W-1:0]   o_blk_idx,
    output logic                   o_frame_start,
    output logic                   o_frame_done,
    output logic [LVL_W-1:0]       o_fifo_level,
    output logic                   o_overflow_err
);
    localparam int BEAT_W = BEATS_PER_FRAME > 1 ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int BB_W   = BEATS_PER_BLK > 1 ? $clog2(BEATS_PER_BLK) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int E_W    = BLK_IDX_W + 2 * SHIFT_WIDTH;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [BEAT_W-1:0]      r_beat;
    logic [BB_W-1:0]        r_bbeat;
    logic [BLK_IDX_W-1:0]   r_blk;
    logic [SHIFT_WIDTH-1:0] r_acc_re, r_acc_im;
    logic [E_W-1:0]         r_mem [FIFO_DEPTH];
    logic [LVL_W-1:0]       r_wp, r_rp;
    logic                   r_fs, r_fd, r_ovf;

    logic                   w_accept, w_blk_first, w_blk_last, w_frm_last;
    logic [SHIFT_WIDTH-1:0] w_min_re, w_min_im;
    logic [LVL_W-1:0]       w_level;
    logic                   w_full, w_pop, w_push_req, w_push;
    logic [E_W-1:0]         w_head;

    // flush dominates a same-cycle beat, so that beat is never accepted
    assign w_accept    = i_din_valid && !i_flush;
    assign w_blk_first = r_bbeat == '0;
    assign w_blk_last  = r_bbeat == BB_W'(BEATS_PER_BLK - 1);
    assign w_frm_last  = r_beat == BEAT_W'(BEATS_PER_FRAME - 1);
    assign w_min_re    = (w_blk_first || i_shift_amt_re < r_acc_re) ? i_shift_amt_re : r_acc_re;
    assign w_min_im    = (w_blk_first || i_shift_amt_im < r_acc_im) ? i_shift_amt_im : r_acc_im;
    assign w_level     = r_wp - r_rp;
    assign w_full      = w_level == LVL_W'(FIFO_DEPTH);
    assign w_pop       = (w_level != '0) && i_exp_ready;
    assign w_push_req  = w_accept && w_blk_last;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_head      = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_bbeat  <= '0;
            r_blk    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_fs     <= 1'b0;
            r_fd     <= 1'b0;
        end else begin
            r_fs <= w_accept && r_state == S_IDLE;
            r_fd <= w_accept && w_frm_last;
            if (w_accept) begin
                r_state  <= w_frm_last ? S_IDLE : S_RUN;
                r_beat   <= w_frm_last ? '0 : r_beat + 1'b1;
                r_bbeat  <= w_blk_last ? '0 : r_bbeat + 1'b1;
                r_blk    <= w_frm_last ? '0 : (w_blk_last ? r_blk + 1'b1 : r_blk);
                r_acc_re <= w_min_re;
                r_acc_im <= w_min_im;
            end
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) r_mem[r_wp[AW-1:0]] <= {r_blk, w_min_re, w_min_im};
    end

    // sticky drop flag survives flush
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ovf <= 1'b0;
        else if (w_push_req && !w_push) r_ovf <= 1'b1;
    end

    assign o_exp_valid    = w_level != '0;
    assign o_blk_idx      = o_exp_valid ? w_head[E_W-1 -: BLK_IDX_W] : '0;
    assign o_blk_exp_re   = o_exp_valid ? w_head[2*SHIFT_WIDTH-1 -: SHIFT_WIDTH] : '0;
    assign o_blk_exp_im   = o_exp_valid ? w_head[SHIFT_WIDTH-1:0] : '0;
    assign o_frame_start  = r_fs;
    assign o_frame_done   = r_fd;
    assign o_fifo_level   = w_level;
    assign o_overflow_err = r_ovf;
endmodule

// File: tb/tb_cbfp_block_exp_ctrl.sv
// tb_cbfp_block_exp_ctrl: directed scenarios plus random traffic, checked every cycle against
// a queue-based model of blocks, frames and the exponent FIFO.
module tb_cbfp_block_exp_ctrl;
    localparam int BPB = 4;
    localparam int BPF = 32;
    localparam int D   = 8;

    logic       clk = 1'b0;
    logic       rst, din_valid, flush, exp_ready;
    logic [4:0] re_in, im_in;
    logic       exp_valid, frame_start, frame_done, overflow_err;
    logic [4:0] blk_exp_re, blk_exp_im;
    logic [2:0] blk_idx;
    logic [3:0] fifo_level;

    always #5 clk = ~clk;

    cbfp_block_exp_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_din_valid(din_valid),
        .i_shift_amt_re(re_in), .i_shift_amt_im(im_in),
        .i_flush(flush), .i_exp_ready(exp_ready),
        .o_exp_valid(exp_valid), .o_blk_exp_re(blk_exp_re), .o_blk_exp_im(blk_exp_im),
        .o_blk_idx(blk_idx), .o_frame_start(frame_start), .o_frame_done(frame_done),
        .o_fifo_level(fifo_level), .o_overflow_err(overflow_err)
    );

    typedef struct {int idx; int re; int im;} ent_t;
    ent_t q[$];
    int   br[$], bi[$];
    int   fbeat;
    bit   movf, mfs, mfd;
    int   total = 0, bad = 0;
    int   pat[4] = '{12, 5, 20, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qmin(input int a[$]);
        int m = a[0];
        foreach (a[i]) if (a[i] < m) m = a[i];
        return m;
    endfunction

    task automatic model(input bit r, input bit v, input bit fl, input bit rdy, input int re, input int im);
        ent_t e;
        mfs = 0;
        mfd = 0;
        if (r || fl) begin
            q.delete(); br.delete(); bi.delete();
            fbeat = 0;
            if (r) movf = 0;
            return;
        end
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (v) begin
            if (fbeat == 0) mfs = 1;
            br.push_back(re);
            bi.push_back(im);
            if (br.size() == BPB) begin
                e.idx = fbeat / BPB;
                e.re  = qmin(br);
                e.im  = qmin(bi);
                br.delete(); bi.delete();
                if (q.size() < D) q.push_back(e);
                else movf = 1;
            end
            fbeat++;
            if (fbeat == BPF) begin
                mfd = 1;
                fbeat = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input bit fl, input bit rdy, input int re, input int im);
        @(negedge clk);
        rst = r; din_valid = v; flush = fl; exp_ready = rdy;
        re_in = re[4:0]; im_in = im[4:0];
        model(r, v, fl, rdy, re, im);
        @(posedge clk);
        #1;
        check("valid", exp_valid, q.size() > 0);
        check("level", fifo_level, q.size());
        check("frame_start", frame_start, mfs);
        check("frame_done", frame_done, mfd);
        check("overflow", overflow_err, movf);
        if (q.size() > 0) begin
            check("blk_idx", blk_idx, q[0].idx);
            check("exp_re", blk_exp_re, q[0].re);
            check("exp_im", blk_exp_im, q[0].im);
        end
    endtask

    initial begin
        rst = 1; din_valid = 0; flush = 0; exp_ready = 0; re_in = 0; im_in = 0;
        fbeat = 0; movf = 0;
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        check("rst_re", blk_exp_re, 0);
        check("rst_im", blk_exp_im, 0);
        check("rst_idx", blk_idx, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, 1, i % 7 + 3, 9);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, 1, pat[i % 4], $urandom_range(0, 31));
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, 0, $urandom_range(0, 31), $urandom_range(0, 31));
        check("full_level", fifo_level, 8);
        check("full_noerr", overflow_err, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, i % 4 == 3, $urandom_range(0, 31), $urandom_range(0, 31));
        check("pushpop_level", fifo_level, 8);
        check("pushpop_noerr", overflow_err, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, 0, $urandom_range(0, 31), $urandom_range(0, 31));
        check("ovf_set", overflow_err, 1);
        repeat (12) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i <= 10; i++) cyc(0, 1, i == 10, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 31));
        check("flush_valid", exp_valid, 0);
        check("flush_level", fifo_level, 0);
        for (int i = 0; i < BPF; i++) cyc(0, 1, 0, 1, $urandom_range(0, 31), $urandom_range(0, 31));
        for (int c = 0; c < 3 * 2 * BPF; c++) cyc(0, c % 3 == 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31));
        for (int c = 0; c < 3000; c++)
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom_range(0, 31));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
